// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       is_zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] imm_src;
  logic       illegal;

  // Controller side
  modport master (
    input  op, funct3, funct7, is_zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal
  );

  // Datapath side
  modport slave (
    output op, funct3, funct7, is_zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory ready handshake, optional bne and a
// sticky illegal-instruction trap.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit BNE_EN        = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       ready;
  logic       alu_f3_ok;
  logic       br_f3_ok;
  logic [2:0] funct_ctrl;

  // Ready is forced high when the handshake is disabled
  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // Legal funct3 classes for ALU and branch instructions
  always_comb begin
    alu_f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
    br_f3_ok  = (bus.funct3 == 3'b000) || (BNE_EN && (bus.funct3 == 3'b001));
  end

  // ALU operation for EXECR/EXECI; only R-type (op[5]=1) can select sub
  always_comb begin
    funct_ctrl = ALU_ADD;
    case (bus.funct3)
      3'b000:  funct_ctrl = (bus.op[5] & bus.funct7) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_ctrl = ALU_SLT;
      3'b110:  funct_ctrl = ALU_OR;
      3'b111:  funct_ctrl = ALU_AND;
      default: funct_ctrl = ALU_ADD;
    endcase
  end

  // State register and sticky trap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = alu_f3_ok ? S_EXECR : S_TRAP;
          OP_I:              state_d = alu_f3_ok ? S_EXECI : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_BR:             state_d = br_f3_ok ? S_BRANCH : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  // Output decode from state; strobes forced low while reset is held
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_ctrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = ready;
        bus.pc_write   = ready;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_ctrl  = funct_ctrl;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_ctrl  = funct_ctrl;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 2'b10;
        bus.alu_ctrl  = ALU_SUB;
        bus.pc_write  = (bus.funct3 == 3'b001) ? ~bus.is_zero : bus.is_zero;
      end
      default: ;
    endcase
    if (rst) begin
      bus.mem_req   = 1'b0;
      bus.mem_write = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.reg_write = 1'b0;
    end
  end

  // Immediate format selected directly from the opcode
  always_comb begin
    case (bus.op)
      OP_STORE: bus.imm_src = 2'b01;
      OP_BR:    bus.imm_src = 2'b10;
      OP_JAL:   bus.imm_src = 2'b11;
      default:  bus.imm_src = 2'b00;
    endcase
  end

  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MWB = 4, MW = 5,
                 XR = 6, AWB = 7, XI = 8, JL = 9, BR = 10, TR = 11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic       illegal;
  } ovec_t;

  typedef struct {
    string nm;
    ovec_t v;
    ovec_t m;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = OP_R;
  logic [2:0] funct3 = 3'b000;
  logic       funct7 = 1'b0;
  logic       is_zero = 1'b0;
  logic       mem_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  exp_t  exp_q[$];
  ovec_t cap_q[$];
  ovec_t obs;

  multicycle_controller_if bus ();
  multicycle_controller_if bus2 ();

  assign bus.op = op;          assign bus2.op = op;
  assign bus.funct3 = funct3;  assign bus2.funct3 = funct3;
  assign bus.funct7 = funct7;  assign bus2.funct7 = funct7;
  assign bus.is_zero = is_zero; assign bus2.is_zero = is_zero;
  assign bus.mem_ready = mem_ready; assign bus2.mem_ready = mem_ready;

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .BNE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.master));

  multicycle_controller #(.MEM_HANDSHAKE(1'b0), .BNE_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master));

  always #5 clk = ~clk;

  always_comb obs = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write,
                     bus.pc_write, bus.reg_write, bus.result_src, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_ctrl, bus.illegal};

  // Expected outputs for one state; mask bits select the fields the state defines
  function automatic exp_t mk(input string nm, input int st, input logic [2:0] alu,
                              input logic mr, input logic pcw);
    exp_t e;
    e.nm = nm; e.v = '0; e.m = '0;
    e.m.mem_req = 1'b1; e.m.mem_write = 1'b1; e.m.ir_write = 1'b1;
    e.m.pc_write = 1'b1; e.m.reg_write = 1'b1; e.m.illegal = 1'b1;
    case (st)
      FE: begin
        e.v.mem_req = 1'b1; e.v.b = 2'b10; e.v.result_src = 2'b10;
        e.v.ir_write = mr; e.v.pc_write = mr;
        e.m.adr_src = 1'b1; e.m.a = '1; e.m.b = '1; e.m.alu = '1; e.m.result_src = '1;
      end
      DE: begin
        e.v.a = 2'b01; e.v.b = 2'b01;
        e.m.a = '1; e.m.b = '1; e.m.alu = '1;
      end
      MA: begin
        e.v.a = 2'b10; e.v.b = 2'b01;
        e.m.a = '1; e.m.b = '1; e.m.alu = '1;
      end
      MR: begin
        e.v.mem_req = 1'b1; e.v.adr_src = 1'b1; e.m.adr_src = 1'b1;
      end
      MWB: begin
        e.v.result_src = 2'b01; e.v.reg_write = 1'b1; e.m.result_src = '1;
      end
      MW: begin
        e.v.mem_req = 1'b1; e.v.mem_write = 1'b1; e.v.adr_src = 1'b1; e.m.adr_src = 1'b1;
      end
      XR: begin
        e.v.a = 2'b10; e.v.b = 2'b00; e.v.alu = alu;
        e.m.a = '1; e.m.b = '1; e.m.alu = '1;
      end
      XI: begin
        e.v.a = 2'b10; e.v.b = 2'b01; e.v.alu = alu;
        e.m.a = '1; e.m.b = '1; e.m.alu = '1;
      end
      AWB: begin
        e.v.result_src = 2'b00; e.v.reg_write = 1'b1; e.m.result_src = '1;
      end
      JL: begin
        e.v.a = 2'b01; e.v.b = 2'b10; e.v.pc_write = 1'b1;
        e.m.a = '1; e.m.b = '1; e.m.alu = '1; e.m.result_src = '1;
      end
      BR: begin
        e.v.a = 2'b10; e.v.b = 2'b00; e.v.alu = 3'b001; e.v.pc_write = pcw;
        e.m.a = '1; e.m.b = '1; e.m.alu = '1; e.m.result_src = '1;
      end
      default: e.v.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7);
    case (f3)
      3'b000:  return (o == OP_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // Drive one cycle, queue its expectation, capture outputs on the falling edge
  task automatic tick(input exp_t e, input logic mr, input logic iz);
    mem_ready = mr;
    is_zero = iz;
    exp_q.push_back(e);
    @(negedge clk);
    cap_q.push_back(obs);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Spec-derived state sequence for one legal instruction
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic iz, input int fw, input int mw);
    logic [2:0] a;
    op = o; funct3 = f3; funct7 = f7;
    a = alu_of(o, f3, f7);
    for (int i = 0; i < fw; i++) tick(mk("fetch_wait", FE, 0, 0, 0), 1'b0, iz);
    tick(mk("fetch", FE, 0, 1'b1, 0), 1'b1, iz);
    tick(mk("decode", DE, 0, 0, 0), 1'b1, iz);
    case (o)
      OP_LOAD: begin
        tick(mk("memadr", MA, 0, 0, 0), 1'b1, iz);
        for (int i = 0; i < mw; i++) tick(mk("memread_wait", MR, 0, 0, 0), 1'b0, iz);
        tick(mk("memread", MR, 0, 0, 0), 1'b1, iz);
        tick(mk("memwb", MWB, 0, 0, 0), 1'b1, iz);
      end
      OP_STORE: begin
        tick(mk("memadr", MA, 0, 0, 0), 1'b1, iz);
        for (int i = 0; i < mw; i++) tick(mk("memwrite_wait", MW, 0, 0, 0), 1'b0, iz);
        tick(mk("memwrite", MW, 0, 0, 0), 1'b1, iz);
      end
      OP_R: begin
        tick(mk("execr", XR, a, 0, 0), 1'b1, iz);
        tick(mk("aluwb", AWB, 0, 0, 0), 1'b1, iz);
      end
      OP_I: begin
        tick(mk("execi", XI, a, 0, 0), 1'b1, iz);
        tick(mk("aluwb", AWB, 0, 0, 0), 1'b1, iz);
      end
      OP_JAL: begin
        tick(mk("jal", JL, 0, 0, 0), 1'b1, iz);
        tick(mk("jal_wb", AWB, 0, 0, 0), 1'b1, iz);
      end
      default: tick(mk("branch", BR, 0, 0, (f3 == 3'b001) ? ~iz : iz), 1'b1, iz);
    endcase
  endtask

  task automatic test_reset;
    exp_t e; ovec_t o;
    do_reset();
    op = OP_STORE; funct3 = 3'b010; funct7 = 1'b0;
    tick(mk("rst_fetch", FE, 0, 1'b1, 0), 1'b1, 1'b0);
    tick(mk("rst_decode", DE, 0, 0, 0), 1'b1, 1'b0);
    tick(mk("rst_memadr", MA, 0, 0, 0), 1'b1, 1'b0);
    tick(mk("rst_memwrite", MW, 0, 0, 0), 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_async_strobes: got %b want 00000",
               {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick(mk("post_rst_fetch_hold", FE, 0, 1'b0, 0), 1'b0, 1'b0);
    tick(mk("post_rst_fetch", FE, 0, 1'b1, 0), 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front(); n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL reset/%s: got %h want %h", e.nm, o & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_add_sub;
    exp_t e; ovec_t o;
    do_reset();
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'b110, 1'b0, 1'b0, 0, 0);
    run_instr(OP_I, 3'b111, 1'b0, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front(); n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL alu/%s: got %h want %h", e.nm, o & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_lw_wait;
    exp_t e; ovec_t o;
    do_reset();
    run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 3);
    run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 2, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front(); n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL mem_wait/%s: got %h want %h", e.nm, o & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_branch;
    exp_t e; ovec_t o;
    do_reset();
    run_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BR, 3'b001, 1'b0, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front(); n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL branch/%s: got %h want %h", e.nm, o & e.m, e.v & e.m);
      end
    end
    do_reset();
    op = OP_BR; funct3 = 3'b001; funct7 = 1'b0;
    tick(mk("bne_fetch", FE, 0, 1'b1, 0), 1'b1, 1'b0);
    tick(mk("bne_decode", DE, 0, 0, 0), 1'b1, 1'b0);
    tick(mk("bne_branch", BR, 0, 0, 1'b1), 1'b1, 1'b0);
    n_cmp++;
    if (bus2.illegal !== 1'b1 || bus2.pc_write !== 1'b0) begin
      n_err++;
      $display("FAIL bne_disabled_trap: got illegal=%b pc_write=%b want illegal=1 pc_write=0",
               bus2.illegal, bus2.pc_write);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front(); n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL bne/%s: got %h want %h", e.nm, o & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_jal;
    exp_t e; ovec_t o;
    do_reset();
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    tick(mk("jal_next_fetch", FE, 0, 1'b0, 0), 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front(); n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL jal/%s: got %h want %h", e.nm, o & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_imm_src;
    logic [6:0] ops [5];
    logic [1:0] want [5];
    ops  = '{OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_I};
    want = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 5; i++) begin
      op = ops[i];
      #1;
      n_cmp++;
      if (bus.imm_src !== want[i]) begin
        n_err++;
        $display("FAIL imm_src[op=%b]: got %b want %b", ops[i], bus.imm_src, want[i]);
      end
    end
  endtask

  task automatic test_trap;
    exp_t e; ovec_t o;
    logic [2:0] bad_f3 [3];
    logic [6:0] bad_op [3];
    bad_op = '{7'h7F, OP_R, OP_BR};
    bad_f3 = '{3'b000, 3'b001, 3'b100};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      op = bad_op[k]; funct3 = bad_f3[k]; funct7 = 1'b0;
      tick(mk("trap_fetch", FE, 0, 1'b1, 0), 1'b1, 1'b0);
      tick(mk("trap_decode", DE, 0, 0, 0), 1'b1, 1'b0);
      for (int i = 0; i < 20; i++)
        tick(mk("trap_hold", TR, 0, 0, 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = cap_q.pop_front(); n_cmp++;
        if ((o & e.m) !== (e.v & e.m)) begin
          n_err++;
          $display("FAIL trap%0d/%s: got %h want %h", k, e.nm, o & e.m, e.v & e.m);
        end
      end
    end
    do_reset();
    #1;
    n_cmp++;
    if (bus.illegal !== 1'b0 || bus.mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL trap_cleared_by_rst: got illegal=%b mem_req=%b want illegal=0 mem_req=1",
               bus.illegal, bus.mem_req);
    end
  endtask

  task automatic test_no_handshake;
    do_reset();
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus2.ir_write !== 1'b1 || bus.ir_write !== 1'b0) begin
      n_err++;
      $display("FAIL handshake_off_fetch: got ir_write nohs=%b hs=%b want nohs=1 hs=0",
               bus2.ir_write, bus.ir_write);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    exp_t e; ovec_t o;
    logic [6:0] seq_op [6];
    logic [2:0] seq_f3 [6];
    seq_op = '{OP_R, OP_LOAD, OP_STORE, OP_I, OP_BR, OP_JAL};
    seq_f3 = '{3'b111, 3'b010, 3'b010, 3'b110, 3'b001, 3'b000};
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 6; i++)
        run_instr(seq_op[i], seq_f3[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = cap_q.pop_front(); n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL back_to_back/%s: got %h want %h", e.nm, o & e.m, e.v & e.m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_lw_wait();
    test_branch();
    test_jal();
    test_imm_src();
    test_trap();
    test_no_handshake();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
